video_timing_gen: RTL

Multi-mode, runtime-switchable raster timing generator. It produces pixel and line counters, sync, active-display, new-line and new-frame strobes, and a wrapping frame counter. It selects one of four standard timing profiles at run time and switches profiles only on frame boundaries, so the raster never tears. It sits at the head of the video pipeline and drives the pixel-fetch, overlay and TMDS-encoder stages on the pixel clock.

---
 rtl/video_timing_pkg.sv | 43 ++++
 rtl/video_timing_gen_decode.sv | 45 ++++
 rtl/video_timing_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Timing profiles and shared types for video_timing_gen.
// Polarity is consumed only when VTG_POLARITY_EN is defined.
package video_timing_pkg;

  localparam int unsigned MAX_H_TOTAL = 2200;
  localparam int unsigned MAX_V_TOTAL = 1125;
  localparam int unsigned HW          = $clog2(MAX_H_TOTAL);
  localparam int unsigned VW          = $clog2(MAX_V_TOTAL);
  localparam int unsigned TBL_MODES   = 4;

  typedef enum logic {
    POL_NEG = 1'b0,
    POL_POS = 1'b1
  } sync_pol_e;

  typedef struct packed {
    logic [HW-1:0] h_active;
    logic [HW-1:0] h_fp;
    logic [HW-1:0] h_sync;
    logic [HW-1:0] h_bp;
    logic [VW-1:0] v_active;
    logic [VW-1:0] v_fp;
    logic [VW-1:0] v_sync;
    logic [VW-1:0] v_bp;
    sync_pol_e     pol;
  } timing_t;

  localparam timing_t TIMING_TABLE [TBL_MODES] = '{
    '{12'd1280, 12'd110, 12'd40,  12'd220, 11'd720,  11'd5,  11'd5, 11'd20, POL_POS},
    '{12'd640,  12'd16,  12'd96,  12'd48,  11'd480,  11'd10, 11'd2, 11'd33, POL_NEG},
    '{12'd1920, 12'd88,  12'd44,  12'd148, 11'd1080, 11'd4,  11'd5, 11'd36, POL_POS},
    '{12'd800,  12'd40,  12'd128, 12'd88,  11'd600,  11'd1,  11'd4, 11'd23, POL_POS}
  };

  function automatic logic [HW-1:0] h_total(timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [VW-1:0] v_total(timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_decode.sv
// Combinational raster decode: sync, active, new-line and new-frame flags.
// VTG_POLARITY_EN: when defined, per-profile sync polarity is applied.
module timing_decode
  import video_timing_pkg::*;
(
  input  logic [HW-1:0] hcount_i,
  input  logic [VW-1:0] vcount_i,
  input  timing_t       prof_i,
  output logic          hs_o,
  output logic          vs_o,
  output logic          ad_o,
  output logic          nl_o,
  output logic          nf_o
);

  logic [HW-1:0] hs_start, hs_stop;
  logic [VW-1:0] vs_start, vs_stop;
  logic          hs_raw, vs_raw;
  logic          unused_bp;

  assign unused_bp = ^{prof_i.h_bp, prof_i.v_bp};

  always_comb begin
    hs_start = prof_i.h_active + prof_i.h_fp;
    hs_stop  = hs_start + prof_i.h_sync;
    vs_start = prof_i.v_active + prof_i.v_fp;
    vs_stop  = vs_start + prof_i.v_sync;
    hs_raw   = (hcount_i >= hs_start) && (hcount_i < hs_stop);
    vs_raw   = (vcount_i >= vs_start) && (vcount_i < vs_stop);
    ad_o     = (hcount_i < prof_i.h_active) && (vcount_i < prof_i.v_active);
    nl_o     = (hcount_i == '0);
    nf_o     = (hcount_i == '0) && (vcount_i == prof_i.v_active);
  end

`ifdef VTG_POLARITY_EN
  assign hs_o = (prof_i.pol == POL_POS) ? hs_raw : !hs_raw;
  assign vs_o = (prof_i.pol == POL_POS) ? vs_raw : !vs_raw;
`else
  logic unused_pol;
  assign unused_pol = prof_i.pol;
  assign hs_o       = hs_raw;
  assign vs_o       = vs_raw;
`endif

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode raster timing generator; profile switches only at frame wrap.
// VTG_POLARITY_EN: when defined, per-profile sync polarity is honoured.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned FPS        = 60,
  parameter int unsigned NUM_MODES  = 4,
  parameter int unsigned RESET_MODE = 0
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_in,
  input  logic [$clog2(NUM_MODES)-1:0]  mode_in,
  output logic [$clog2(MAX_H_TOTAL)-1:0] hcount_out,
  output logic [$clog2(MAX_V_TOTAL)-1:0] vcount_out,
  output logic                          hs_out,
  output logic                          vs_out,
  output logic                          ad_out,
  output logic                          nl_out,
  output logic                          nf_out,
  output logic [$clog2(FPS)-1:0]        fc_out,
  output logic [$clog2(NUM_MODES)-1:0]  mode_out,
  output logic                          mode_ack_out
);

  localparam int unsigned MW = $clog2(NUM_MODES);
  localparam int unsigned FW = $clog2(FPS);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [MW-1:0] mode_q, mode_d, pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          ack_q, ack_d;
  logic [FW-1:0] fc_q, fc_d;
  timing_t       prof;
  logic          last_h, last_v, wrap, req_vld;
  logic          ad_raw, nf_raw;

  assign prof    = TIMING_TABLE[mode_q];
  assign last_h  = (hcount_q == h_total(prof) - 1'b1);
  assign last_v  = (vcount_q == v_total(prof) - 1'b1);
  assign wrap    = last_h && last_v;
  assign req_vld = (mode_in != mode_q) && (32'(mode_in) < NUM_MODES);

  assign hcount_d = last_h ? '0 : hcount_q + 1'b1;
  assign vcount_d = !last_h ? vcount_q : (last_v ? '0 : vcount_q + 1'b1);

  always_comb begin
    mode_d     = mode_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    fc_d       = fc_q;
    if (nf_raw) fc_d = (fc_q == FW'(FPS - 1)) ? '0 : fc_q + 1'b1;
    // A valid request seen on the wrap cycle itself overrides the pending one.
    if (wrap) begin
      if (req_vld)         mode_d = mode_in;
      else if (pend_vld_q) mode_d = pend_q;
      ack_d      = req_vld || pend_vld_q;
      pend_vld_d = 1'b0;
    end else if (req_vld) begin
      pend_d     = mode_in;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      hcount_q   <= '0;
      vcount_q   <= '0;
      mode_q     <= MW'(RESET_MODE);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      fc_q       <= '0;
    end else begin
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      fc_q       <= fc_d;
    end
  end

  timing_decode u_decode (
    .hcount_i (hcount_q),
    .vcount_i (vcount_q),
    .prof_i   (prof),
    .hs_o     (hs_out),
    .vs_o     (vs_out),
    .ad_o     (ad_raw),
    .nl_o     (nl_out),
    .nf_o     (nf_raw)
  );

  assign ad_out       = ad_raw && !rst_in;
  assign nf_out       = nf_raw && !rst_in;
  assign hcount_out   = hcount_q;
  assign vcount_out   = vcount_q;
  assign fc_out       = fc_q;
  assign mode_out     = mode_q;
  assign mode_ack_out = ack_q;

endmodule
